// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// master: pipeline side (drives hazard inputs, receives controls).
// slave : hazard controller side.
interface hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_regs_rs1;
   logic [REG_ADDR_W-1:0] id_regs_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic                  ex_valid;
   logic [REG_ADDR_W-1:0] ex_regs_rd;
   logic                  ex_ctrl_regs_write;
   logic                  ex_ctrl_mem_read;
   logic                  ex_mc_start;
   logic                  mc_done;
   logic                  ex_branch_taken;
   logic                  mem_req;
   logic                  mem_ready;

   logic                  pc_stall;
   logic                  if_id_stall;
   logic                  if_id_flush;
   logic                  id_ex_stall;
   logic                  id_ex_flush;
   logic                  ex_mem_stall;
   logic                  ex_mem_flush;
   logic                  mc_timeout;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   modport master (
      output id_valid, id_regs_rs1, id_regs_rs2, id_use_rs1, id_use_rs2,
             ex_valid, ex_regs_rd, ex_ctrl_regs_write, ex_ctrl_mem_read,
             ex_mc_start, mc_done, ex_branch_taken, mem_req, mem_ready,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, ex_mem_flush, mc_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_regs_rs1, id_regs_rs2, id_use_rs1, id_use_rs2,
             ex_valid, ex_regs_rd, ex_ctrl_regs_write, ex_ctrl_mem_read,
             ex_mc_start, mc_done, ex_branch_taken, mem_req, mem_ready,
      output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, ex_mem_flush, mc_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller for the 5-stage core: load-use, multi-cycle
// EX, data-memory wait and taken-branch stall/flush generation, with
// saturating stall/flush counters and a multi-cycle watchdog.
module hazard_ctrl #(
   parameter int unsigned REG_ADDR_W    = 5,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MC_MAX_CYCLES = 64
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hz
);
   localparam int unsigned MC_W = $clog2(MC_MAX_CYCLES + 1);

   typedef enum logic [1:0] {RUN, MC_WAIT, MEM_WAIT} state_t;

   state_t                state_q, state_d;
   logic [MC_W-1:0]       mc_cnt_q, mc_cnt_d;
   logic                  mc_timeout_q, mc_timeout_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

   logic [REG_ADDR_W-1:0] ex_rd, id_rs1, id_rs2;
   logic                  memstall, mcstall, loaduse;
   logic                  pc_stall, if_id_stall, if_id_flush;
   logic                  id_ex_stall, id_ex_flush;
   logic                  ex_mem_stall, ex_mem_flush;

   assign ex_rd  = hz.ex_regs_rd;
   assign id_rs1 = hz.id_regs_rs1;
   assign id_rs2 = hz.id_regs_rs2;

   // Raw hazard conditions from the current pipeline contents
   always_comb begin
      memstall = hz.mem_req & ~hz.mem_ready;
      mcstall  = hz.ex_valid & hz.ex_mc_start & ~hz.mc_done;
      loaduse  = hz.ex_valid & hz.ex_ctrl_mem_read & hz.ex_ctrl_regs_write &
                 (ex_rd != '0) & hz.id_valid &
                 ((hz.id_use_rs1 & (id_rs1 == ex_rd)) |
                  (hz.id_use_rs2 & (id_rs2 == ex_rd)));
   end

   // Next-state, watchdog and stall/flush controls; all controls low in reset
   always_comb begin
      state_d      = state_q;
      mc_cnt_d     = mc_cnt_q;
      mc_timeout_d = mc_timeout_q;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      ex_mem_flush = 1'b0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (memstall) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = 1'b1;
                  state_d      = MEM_WAIT;
               end else if (mcstall) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_flush = 1'b1;
                  state_d      = MC_WAIT;
                  mc_cnt_d     = MC_W'(1);
               end else if (hz.ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (loaduse) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!hz.mem_ready) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            MC_WAIT: begin
               if (hz.mc_done) begin
                  state_d  = RUN;
                  mc_cnt_d = '0;
               end else begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = memstall;
                  ex_mem_flush = ~memstall;
                  if (mc_cnt_q == MC_W'(MC_MAX_CYCLES)) begin
                     mc_timeout_d = 1'b1;
                     state_d      = RUN;
                     mc_cnt_d     = '0;
                  end else begin
                     mc_cnt_d = mc_cnt_q + MC_W'(1);
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Saturating performance counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State, watchdog and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         mc_cnt_q     <= '0;
         mc_timeout_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         mc_cnt_q     <= mc_cnt_d;
         mc_timeout_q <= mc_timeout_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   // Stall takes precedence over flush on every pipeline register
   assign hz.pc_stall     = pc_stall;
   assign hz.if_id_stall  = if_id_stall;
   assign hz.if_id_flush  = if_id_flush & ~if_id_stall;
   assign hz.id_ex_stall  = id_ex_stall;
   assign hz.id_ex_flush  = id_ex_flush & ~id_ex_stall;
   assign hz.ex_mem_stall = ex_mem_stall;
   assign hz.ex_mem_flush = ex_mem_flush & ~ex_mem_stall;
   assign hz.mc_timeout   = mc_timeout_q;
   assign hz.stall_cnt    = stall_cnt_q;
   assign hz.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, counter saturation on a narrow instance, and
// randomized stimulus against a behavioural reference model.
module tb_hazard_ctrl;
   localparam int unsigned MCMAX = 6;

   // control bits: {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f}
   typedef logic [6:0] ctl_t;
   localparam ctl_t E_NONE = 7'b0000000;
   localparam ctl_t E_LU   = 7'b1100100;
   localparam ctl_t E_BR   = 7'b0010100;
   localparam ctl_t E_MEM  = 7'b1101010;
   localparam ctl_t E_MC   = 7'b1101001;

   typedef struct packed {
      logic       idv;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       exv;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       mcs;
      logic       done;
      logic       br;
      logic       req;
      logic       rdy;
   } in_t;

   typedef struct {
      in_t  i;
      ctl_t e;
   } vec_t;

   logic clk;
   logic rst;

   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();
   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  hs ();

   hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .MC_MAX_CYCLES(MCMAX)) dut (
      .clk(clk), .rst(rst), .hz(hz.slave));
   hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2), .MC_MAX_CYCLES(MCMAX)) dut_sat (
      .clk(clk), .rst(rst), .hz(hs.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_vec = 0;
   int   n_err = 0;
   in_t  cur_in;
   logic cur_rst;

   // reference model state
   bit          m_mem, m_mc, m_to;
   int          m_el;
   logic [31:0] m_scnt, m_fcnt;

   function automatic in_t mk(logic idv, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic exv, logic [4:0] rd, logic rw, logic mr,
                              logic mcs, logic done, logic br, logic req, logic rdy);
      in_t v;
      v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.exv = exv; v.rd = rd; v.rw = rw; v.mr = mr;
      v.mcs = mcs; v.done = done; v.br = br; v.req = req; v.rdy = rdy;
      return v;
   endfunction

   function automatic ctl_t model_ctl(in_t i, logic r);
      logic ms, mc, lu;
      ms = i.req & ~i.rdy;
      mc = i.exv & i.mcs & ~i.done;
      lu = i.exv & i.mr & i.rw & (i.rd != 5'd0) & i.idv &
           ((i.u1 & (i.rs1 == i.rd)) | (i.u2 & (i.rs2 == i.rd)));
      if (r)           return E_NONE;
      if (m_mem)       return i.rdy ? E_NONE : E_MEM;
      if (m_mc)        return i.done ? E_NONE : (ms ? E_MEM : E_MC);
      if (ms)          return E_MEM;
      if (mc)          return E_MC;
      if (i.br)        return E_BR;
      if (lu)          return E_LU;
      return E_NONE;
   endfunction

   task automatic model_update(in_t i, logic r);
      ctl_t c;
      c = model_ctl(i, r);
      if (r) begin
         m_mem = 0; m_mc = 0; m_to = 0; m_el = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
         if (c[6] && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
         if (c[4] && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
         if (m_mem) begin
            if (i.rdy) m_mem = 0;
         end else if (m_mc) begin
            if (i.done) m_mc = 0;
            else if (m_el == int'(MCMAX)) begin m_to = 1; m_mc = 0; end
            else m_el = m_el + 1;
         end else if (i.req && !i.rdy) begin
            m_mem = 1;
         end else if (i.exv && i.mcs && !i.done) begin
            m_mc = 1; m_el = 1;
         end
      end
   endtask

   function automatic ctl_t dut_ctl();
      return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
              hz.id_ex_flush, hz.ex_mem_stall, hz.ex_mem_flush};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // drive at the falling edge, let combinational outputs settle
   task automatic apply(in_t v, logic r);
      cur_in = v; cur_rst = r; rst = r;
      hz.id_valid = v.idv; hz.id_regs_rs1 = v.rs1; hz.id_use_rs1 = v.u1;
      hz.id_regs_rs2 = v.rs2; hz.id_use_rs2 = v.u2;
      hz.ex_valid = v.exv; hz.ex_regs_rd = v.rd; hz.ex_ctrl_regs_write = v.rw;
      hz.ex_ctrl_mem_read = v.mr; hz.ex_mc_start = v.mcs; hz.mc_done = v.done;
      hz.ex_branch_taken = v.br; hz.mem_req = v.req; hz.mem_ready = v.rdy;
      #1;
   endtask

   task automatic adv();
      model_update(cur_in, cur_rst);
      @(negedge clk);
   endtask

   task automatic run(in_t v, logic r, ctl_t e, string nm);
      apply(v, r);
      chk(nm, 32'(dut_ctl()), 32'(e));
      adv();
   endtask

   task automatic do_reset();
      apply('0, 1'b1);
      chk("rst_ctl", 32'(dut_ctl()), 32'(E_NONE));
      adv();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   vec_t tv[24];
   in_t  idle, v, lu5, vm;

   initial begin
      idle = '0;
      rst  = 1'b1;
      hs.id_valid = 0; hs.id_regs_rs1 = '0; hs.id_regs_rs2 = '0; hs.id_use_rs1 = 0;
      hs.id_use_rs2 = 0; hs.ex_valid = 0; hs.ex_regs_rd = '0; hs.ex_ctrl_regs_write = 0;
      hs.ex_ctrl_mem_read = 0; hs.ex_mc_start = 0; hs.mc_done = 0;
      hs.ex_branch_taken = 0; hs.mem_req = 0; hs.mem_ready = 0;
      apply(idle, 1'b1);
      @(negedge clk);

      //            idv rs1 u1 rs2 u2  exv rd rw mr  mcs dn br  req rdy
      tv[0]  = '{mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0), E_NONE};
      tv[1]  = '{mk(1, 5, 1, 0, 0,  1, 5, 1, 1,  0, 0, 0,  0, 0), E_LU};
      tv[2]  = '{mk(1, 0, 1, 0, 0,  1, 0, 1, 1,  0, 0, 0,  0, 0), E_NONE};
      tv[3]  = '{mk(1, 3, 1, 5, 1,  1, 5, 1, 1,  0, 0, 0,  0, 0), E_LU};
      tv[4]  = '{mk(1, 5, 0, 0, 0,  1, 5, 1, 1,  0, 0, 0,  0, 0), E_NONE};
      tv[5]  = '{mk(1, 5, 1, 0, 0,  0, 5, 1, 1,  0, 0, 0,  0, 0), E_NONE};
      tv[6]  = '{mk(1, 5, 1, 0, 0,  1, 5, 1, 0,  0, 0, 0,  0, 0), E_NONE};
      tv[7]  = '{mk(1, 5, 1, 0, 0,  1, 5, 0, 1,  0, 0, 0,  0, 0), E_NONE};
      tv[8]  = '{mk(0, 5, 1, 0, 0,  1, 5, 1, 1,  0, 0, 0,  0, 0), E_NONE};
      tv[9]  = '{mk(1, 5, 1, 0, 0,  1, 5, 1, 1,  0, 0, 1,  0, 0), E_BR};
      tv[10] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 1, 0,  0, 0), E_NONE};
      tv[11] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 1, 1,  0, 0), E_BR};
      tv[12] = '{mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  1, 1), E_NONE};
      tv[13] = '{mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  1, 0), E_MEM};
      tv[14] = '{mk(1, 5, 1, 0, 0,  1, 5, 1, 1,  1, 0, 1,  1, 0), E_MEM};
      tv[15] = '{mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  1, 1), E_NONE};
      tv[16] = '{mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 0), E_BR};
      tv[17] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 0, 1,  1, 1), E_MC};
      tv[18] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 0, 0,  1, 0), E_MEM};
      tv[19] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 1, 0,  0, 0), E_NONE};
      tv[20] = '{mk(1, 2, 0, 9, 1,  1, 9, 1, 1,  0, 0, 0,  0, 0), E_LU};
      tv[21] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 0, 0,  1, 0), E_MEM};
      tv[22] = '{mk(0, 0, 0, 0, 0,  1, 7, 1, 0,  1, 0, 0,  1, 1), E_NONE};
      tv[23] = '{mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 0), E_BR};

      // reset state
      do_reset();
      apply(idle, 1'b0);
      chk("reset_ctl", 32'(dut_ctl()), 32'(E_NONE));
      chk("reset_stall_cnt", hz.stall_cnt, 0);
      chk("reset_flush_cnt", hz.flush_cnt, 0);
      chk("reset_timeout", 32'(hz.mc_timeout), 0);
      adv();

      // directed vector table
      for (int k = 0; k < 24; k++) run(tv[k].i, 1'b0, tv[k].e, $sformatf("vec%0d", k));

      // load-use: one stall cycle, rd=0 ignored
      do_reset();
      lu5 = tv[1].i;
      run(lu5, 1'b0, E_LU, "lu_stall");
      apply(idle, 1'b0);
      chk("lu_next_ctl", 32'(dut_ctl()), 32'(E_NONE));
      chk("lu_stall_cnt", hz.stall_cnt, 1);
      adv();
      run(tv[2].i, 1'b0, E_NONE, "lu_x0");
      // branch with load-use in the same cycle
      v = lu5; v.br = 1'b1;
      run(v, 1'b0, E_BR, "br_lu");
      apply(idle, 1'b0);
      chk("br_lu_stall_cnt", hz.stall_cnt, 1);
      chk("br_lu_flush_cnt", hz.flush_cnt, 1);
      adv();

      // divide: done five cycles after start
      do_reset();
      vm = mk(0, 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) run(vm, 1'b0, E_MC, $sformatf("div_stall%0d", k));
      v = vm; v.done = 1'b1;
      run(v, 1'b0, E_NONE, "div_done");
      v = idle; v.br = 1'b1;
      apply(v, 1'b0);
      chk("div_back_run", 32'(dut_ctl()), 32'(E_BR));
      chk("div_stall_cnt", hz.stall_cnt, 5);
      adv();

      // memory wait: three frozen cycles with branch ignored
      do_reset();
      v = idle; v.req = 1'b1; v.br = 1'b1;
      for (int k = 0; k < 3; k++) run(v, 1'b0, E_MEM, $sformatf("mem_freeze%0d", k));
      v.rdy = 1'b1;
      run(v, 1'b0, E_NONE, "mem_release");
      v = idle; v.br = 1'b1;
      apply(v, 1'b0);
      chk("mem_back_run", 32'(dut_ctl()), 32'(E_BR));
      chk("mem_stall_cnt", hz.stall_cnt, 3);
      chk("mem_flush_cnt", hz.flush_cnt, 0);
      adv();
      // memory stall while waiting on a multi-cycle op
      run(vm, 1'b0, E_MC, "mcmem_enter");
      v = vm; v.req = 1'b1;
      run(v, 1'b0, E_MEM, "mcmem_hold0");
      run(v, 1'b0, E_MEM, "mcmem_hold1");
      v = vm; v.done = 1'b1;
      run(v, 1'b0, E_NONE, "mcmem_done");

      // watchdog, sticky flag, then reset mid-wait
      do_reset();
      for (int k = 0; k <= int'(MCMAX); k++) begin
         apply(vm, 1'b0);
         chk("wd_early", 32'(hz.mc_timeout), 0);
         chk($sformatf("wd_stall%0d", k), 32'(dut_ctl()), 32'(E_MC));
         adv();
      end
      v = idle; v.br = 1'b1;
      apply(v, 1'b0);
      chk("wd_flag", 32'(hz.mc_timeout), 1);
      chk("wd_back_run", 32'(dut_ctl()), 32'(E_BR));
      adv();
      for (int k = 0; k < 3; k++) begin
         apply(idle, 1'b0);
         chk("wd_sticky", 32'(hz.mc_timeout), 1);
         adv();
      end
      run(vm, 1'b0, E_MC, "rstmid_enter");
      run(vm, 1'b0, E_MC, "rstmid_wait");
      apply(vm, 1'b1);
      chk("rstmid_ctl", 32'(dut_ctl()), 32'(E_NONE));
      adv();
      v = idle; v.br = 1'b1;
      apply(v, 1'b0);
      chk("rstmid_run", 32'(dut_ctl()), 32'(E_BR));
      chk("rstmid_stall_cnt", hz.stall_cnt, 0);
      chk("rstmid_flush_cnt", hz.flush_cnt, 0);
      chk("rstmid_timeout", 32'(hz.mc_timeout), 0);
      adv();

      // counter saturation on the 2-bit instance
      do_reset();
      hs.ex_branch_taken = 1'b1;
      for (int k = 0; k < 5; k++) begin apply(idle, 1'b0); adv(); end
      hs.ex_branch_taken = 1'b0;
      hs.mem_req = 1'b1;
      for (int k = 0; k < 5; k++) begin apply(idle, 1'b0); adv(); end
      apply(idle, 1'b0);
      chk("sat_flush_cnt", 32'(hs.flush_cnt), 3);
      chk("sat_stall_cnt", 32'(hs.stall_cnt), 3);
      hs.mem_ready = 1'b1;
      adv();
      hs.mem_req = 1'b0;
      hs.mem_ready = 1'b0;

      // randomized stimulus against the reference model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic r;
         v.idv  = ($urandom_range(0, 3) != 0);
         v.rs1  = 5'($urandom_range(0, 3));
         v.u1   = 1'($urandom_range(0, 1));
         v.rs2  = 5'($urandom_range(0, 3));
         v.u2   = 1'($urandom_range(0, 1));
         v.exv  = ($urandom_range(0, 3) != 0);
         v.rd   = 5'($urandom_range(0, 3));
         v.rw   = 1'($urandom_range(0, 1));
         v.mr   = 1'($urandom_range(0, 1));
         v.mcs  = ($urandom_range(0, 3) == 0);
         v.done = ($urandom_range(0, 7) == 0);
         v.br   = ($urandom_range(0, 5) == 0);
         v.req  = ($urandom_range(0, 2) == 0);
         v.rdy  = 1'($urandom_range(0, 1));
         r      = ($urandom_range(0, 299) == 0);
         apply(v, r);
         chk("rnd_ctl", 32'(dut_ctl()), 32'(model_ctl(v, r)));
         chk("rnd_stall_cnt", hz.stall_cnt, m_scnt);
         chk("rnd_flush_cnt", hz.flush_cnt, m_fcnt);
         chk("rnd_timeout", 32'(hz.mc_timeout), 32'(m_to));
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
